// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// The FSM encoding is fixed so external observers can decode the state.
package dmem_responder_pkg;

  localparam int DMEM_WORDS = 32;
  localparam int IDX_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_responder_latency_counter.sv
// 4-bit wait-cycle counter: parallel load, saturating decrement, zero flag.
module latency_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // next count: load wins over decrement, decrement stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the pipeline MEM stage.
// One request in flight; response pulses LATENCY+1 cycles after acceptance.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e             state_q, state_d;
  logic               write_q, write_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               mis_q, mis_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic [31:0]        mem_q [DMEM_WORDS];

  logic               accept_s;
  logic               finish_s;
  logic               commit_s;
  logic               cnt_dec_s;
  logic               cnt_zero_s;
  logic               unused_addr_s;

  assign unused_addr_s = ^req_addr[31:7];

  assign accept_s  = req_valid && (state_q == ST_IDLE);
  assign finish_s  = (state_q == ST_WAIT) && cnt_zero_s;
  assign commit_s  = finish_s && write_q && !mis_q;
  assign cnt_dec_s = (state_q == ST_WAIT) && !cnt_zero_s;

  latency_counter u_latency_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (accept_s),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_zero_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // request capture and response data path
  always_comb begin
    write_d     = write_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    mis_d       = mis_q;
    rsp_valid_d = finish_s;
    rsp_err_d   = finish_s && mis_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept_s) begin
      write_d = req_write;
      idx_d   = req_addr[6:2];
      wdata_d = req_wdata;
      mis_d   = is_misaligned(req_addr[1:0]);
    end else begin
      write_d = write_q;
    end
    // stores and misaligned accesses return zero data
    if (finish_s) begin
      if (write_q || mis_q) begin
        rsp_rdata_d = 32'h0000_0000;
      end else begin
        rsp_rdata_d = mem_q[idx_q];
      end
    end else begin
      rsp_rdata_d = rsp_rdata_q;
    end
  end

  // control and response registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'h0000_0000;
      mis_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      mis_q       <= mis_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // storage array, cleared by reset so an aborted store leaves nothing behind
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (commit_s) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign stall     = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_WAIT);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
